// File: rtl/fetch_stage.sv
// SPARC-style instruction fetch stage: pc/npc sequencing, IF/ID register, stall/bubble/annul handling.
// Optional fetch/stall performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 9
) (
    input  logic              clk,
    input  logic              clr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              imem_valid,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              annul,
    output logic [31:0]       pc,
    output logic [31:0]       npc,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    output logic              instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count
`endif
);

    localparam logic [31:0] RESET_NPC = 32'(RESET_PC + 32'd4);

    logic [31:0] pc_q, pc_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        advance_c;
    logic        unused_tgt_c;

    // Targets are word aligned; the two low bits are dropped by design.
    assign unused_tgt_c = ^branch_target[1:0];

    assign advance_c = ~stall & imem_valid;

    always_comb begin
        pc_d          = pc_q;
        npc_d         = npc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        if (advance_c) begin
            pc_d       = npc_q;
            npc_d      = branch_taken ? {branch_target[31:2], 2'b00} : 32'(npc_q + 32'd4);
            instr_pc_d = pc_q;
            if (annul) begin
                instr_d       = 32'h0;
                instr_valid_d = 1'b0;
            end else begin
                instr_d       = imem_data;
                instr_valid_d = 1'b1;
            end
        end else if (!stall) begin
            // ROM not ready: insert a bubble but keep the last instruction word.
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q          <= RESET_PC;
            npc_q         <= RESET_NPC;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            npc_q         <= npc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_addr   = pc_q[ADDR_W-1:0];
    assign pc          = pc_q;
    assign npc         = npc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [15:0] stall_count_q, stall_count_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (advance_c && !annul) begin
            fetch_count_d = 16'(fetch_count_q + 16'd1);
        end
        if (!advance_c) begin
            stall_count_d = 16'(stall_count_q + 16'd1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fetch_count_q <= 16'h0;
            stall_count_q <= 16'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 9: width of the instruction-memory byte address (512-byte ROM).
REQ-003 Port clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port clr  input  1  reset, asynchronous, active-high.
REQ-005 Port imem_addr  output  ADDR_W  byte address to instruction ROM, equal to pc[ADDR_W-1:0], combinational.
REQ-006 Port imem_data  input  32  big-endian instruction word returned by the ROM for imem_addr.
REQ-007 Port imem_valid  input  1  imem_data is valid this cycle.
REQ-008 Port stall  input  1  hold request from decode/hazard logic.
REQ-009 Port branch_taken  input  1  control transfer resolved this cycle.
REQ-010 Port branch_target  input  32  target address for branch_taken.
REQ-011 Port annul  input  1  squash the instruction being fetched this cycle (delay-slot annul).
REQ-012 Port pc  output  32  current fetch address.
REQ-013 Port npc  output  32  next fetch address (SPARC nPC).
REQ-014 Port instr  output  32  IF/ID instruction register, feeds control_unit instr.
REQ-015 Port instr_pc  output  32  address of instr.
REQ-016 Port instr_valid  output  1  instr holds a real instruction, not a bubble.

Function
REQ-017 An advance cycle SHALL be one with stall=0 and imem_valid=1.
REQ-018 On advance: pc<=npc; npc<=branch_taken ? {branch_target[31:2],2'b00} : npc+4.
REQ-019 On advance with annul=0: instr<=imem_data, instr_pc<=pc, instr_valid<=1.
REQ-020 On advance with annul=1: instr<=32'h0, instr_pc<=pc, instr_valid<=0; pc/npc still update per REQ-018.
REQ-021 When stall=1: pc, npc, instr, instr_pc, instr_valid SHALL all hold; branch_taken and annul ignored (source SHALL hold them until stall falls).
REQ-022 When stall=0 and imem_valid=0: pc and npc hold; instr_valid<=0, instr and instr_pc hold (bubble).
REQ-023 Latency: ROM word at address A appears on instr one rising edge after the advance cycle fetching A.
REQ-024 Arithmetic: npc+4 SHALL be modulo 2^32 (32'hFFFF_FFFC+4 -> 0); imem_addr SHALL be truncated pc, wrapping at 2^ADDR_W.
REQ-025 Branch takes effect SPARC-style: instruction at old npc (delay slot) is fetched next, then branch_target.
REQ-026 Stall priority: stall > imem_valid=0 > annul > branch_taken.

Reset
REQ-027 On clr=1, asynchronously: pc=RESET_PC, npc=RESET_PC+4, instr=0, instr_pc=0, instr_valid=0.
REQ-028 Reset asserted mid-operation SHALL discard any in-flight branch or annul; first advance after release fetches RESET_PC.
REQ-029 While clr=1 no state SHALL change on clk edges.

Configuration
REQ-030 Macro FETCH_PERF_CNT_EN defined: adds output ports fetch_count (16) and stall_count (16); fetch_count increments on every advance with annul=0, stall_count on every cycle with stall=1 or imem_valid=0; both wrap at 16'hFFFF->0 and reset to 0 on clr.
REQ-031 Macro not defined: the two ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-032 clr=1 for 2 edges, then free-run with imem_valid=1 and ROM words W0,W1,W2 at 0,4,8 -> instr=W0,W1,W2 on successive edges, instr_pc=0,4,8, instr_valid=1.
REQ-033 At pc=8,npc=12 assert branch_taken with branch_target=32'h40 for one advance -> next fetches 12 then 0x40; instr_pc sequence 8,12,0x40.
REQ-034 stall=1 for 3 cycles at pc=0x10 -> pc, npc, instr, instr_valid unchanged for 3 edges; on release fetch resumes at 0x10.
REQ-035 annul=1 on advance at pc=0x14 -> instr=0, instr_valid=0, instr_pc=0x14, next pc=0x18.
REQ-036 imem_valid=0 for 2 cycles -> two bubbles (instr_valid=0), pc held; with FETCH_PERF_CNT_EN stall_count +2.
REQ-037 Assert clr asynchronously between edges while pc=0x20 -> pc=0, npc=4, instr_valid=0 immediately; pc=32'hFFFF_FFFC free-run -> npc wraps to 0.
